// File: rtl/snk_video_pkg.sv
// Shared definitions for the layer priority mixer: config map, ctrl layout,
// backdrop index and the default rank/bank tables.
package snk_video_pkg;

   // Positions of the ctrl register bits
   localparam int CTRL_SPR_PRI_BIT = 0;
   localparam int CTRL_SHADOW_BIT  = 1;
   localparam int CTRL_BDBANK_LSB  = 2;
   localparam int CTRL_BDBANK_W    = 3;
   localparam int CTRL_W           = CTRL_BDBANK_LSB + CTRL_BDBANK_W;

   // Ctrl register; the field order matches cfg_data[4:0]
   typedef struct packed {
      logic [CTRL_BDBANK_W-1:0] bd_bank;
      logic                     shadow_en;
      logic                     spr_pri_en;
   } ctrl_t;

   // Config map: rank slots first, then bank registers, then ctrl
   function automatic int cfg_rank_addr(input int k);
      return k;
   endfunction

   function automatic int cfg_bank_addr(input int n, input int i);
      return n + i;
   endfunction

   function automatic int cfg_ctrl_addr(input int n);
      return 2 * n;
   endfunction

   // The winner index one past the last layer stands for the backdrop
   function automatic int backdrop_index(input int n);
      return n;
   endfunction

   // Out of reset every slot ranks its own layer and every layer uses its own bank
   function automatic int default_rank(input int k);
      return k;
   endfunction

   function automatic int default_bank(input int i);
      return i;
   endfunction

endpackage

// File: rtl/prio_cfg_regs.sv
// Double-buffered mixer configuration. CPU writes land in a pending copy that
// is copied into the active copy on the rising edge of hblank, so the visible
// line never sees a half-updated priority table.
module prio_cfg_regs
   import snk_video_pkg::*;
#(
   parameter int NUM_LAYERS = 4,
   parameter int LSEL_W     = $clog2(NUM_LAYERS + 1),
   parameter int BANK_W     = 3,
   parameter int ADDR_W     = $clog2(2 * NUM_LAYERS + 1)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_hblank,
   input  logic                                 i_we,
   input  logic [ADDR_W-1:0]                    i_addr,
   input  logic [7:0]                           i_data,
   output logic                                 o_busy,
   output logic [NUM_LAYERS-1:0][LSEL_W-1:0]    o_rank,
   output logic [NUM_LAYERS-1:0][BANK_W-1:0]    o_bank,
   output ctrl_t                                o_ctrl
);

   localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(cfg_ctrl_addr(NUM_LAYERS));

   logic [NUM_LAYERS-1:0][LSEL_W-1:0] r_rank_pend;
   logic [NUM_LAYERS-1:0][BANK_W-1:0] r_bank_pend;
   ctrl_t                             r_ctrl_pend;
   logic [NUM_LAYERS-1:0][LSEL_W-1:0] r_rank_act;
   logic [NUM_LAYERS-1:0][BANK_W-1:0] r_bank_act;
   ctrl_t                             r_ctrl_act;
   logic                              r_hblank_d;
   logic                              r_busy;
   logic                              w_wr;
   logic                              w_hb_rise;
   logic                              w_unused_data;

   // Every address from 0 up to the ctrl register is mapped; anything above is dropped
   assign w_wr          = i_we && (i_addr <= CTRL_ADDR);
   assign w_hb_rise     = i_hblank && !r_hblank_d;
   assign w_unused_data = &{1'b0, i_data};

   // Pending copy: the last write before the line boundary wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_LAYERS; k++) begin
            r_rank_pend[k] <= LSEL_W'(default_rank(k));
            r_bank_pend[k] <= BANK_W'(default_bank(k));
         end
         r_ctrl_pend <= '0;
      end else if (w_wr) begin
         for (int k = 0; k < NUM_LAYERS; k++) begin
            if (i_addr == ADDR_W'(cfg_rank_addr(k)))
               r_rank_pend[k] <= i_data[LSEL_W-1:0];
            if (i_addr == ADDR_W'(cfg_bank_addr(NUM_LAYERS, k)))
               r_bank_pend[k] <= i_data[BANK_W-1:0];
         end
         if (i_addr == CTRL_ADDR)
            r_ctrl_pend <= ctrl_t'(i_data[CTRL_W-1:0]);
      end
   end

   // Active copy: takes the pending copy as it stood before this cycle's write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_LAYERS; k++) begin
            r_rank_act[k] <= LSEL_W'(default_rank(k));
            r_bank_act[k] <= BANK_W'(default_bank(k));
         end
         r_ctrl_act <= '0;
      end else if (w_hb_rise) begin
         r_rank_act <= r_rank_pend;
         r_bank_act <= r_bank_pend;
         r_ctrl_act <= r_ctrl_pend;
      end
   end

   // Busy flag and hblank edge history; a write coinciding with the edge keeps busy set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hblank_d <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_hblank_d <= i_hblank;
         if (w_wr)
            r_busy <= 1'b1;
         else if (w_hb_rise)
            r_busy <= 1'b0;
      end
   end

   assign o_busy = r_busy;
   assign o_rank = r_rank_act;
   assign o_bank = r_bank_act;
   assign o_ctrl = r_ctrl_act;

endmodule

// File: rtl/layer_prio_mixer.sv
// Two-stage layer priority mixer: stage 1 picks the winning layer from the
// active rank table, stage 2 attaches the colour bank and registers outputs.
module layer_prio_mixer
   import snk_video_pkg::*;
#(
   parameter int                NUM_LAYERS = 4,
   parameter int                PIX_W      = 8,
   parameter int                TRANS_BITS = 3,
   parameter int                BANK_W     = 3,
   parameter logic [PIX_W-1:0]  SHADOW_PEN = 8'hFE,
   parameter int                LSEL_W     = $clog2(NUM_LAYERS + 1)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             ce_pix,
   input  logic                             hblank,
   input  logic [NUM_LAYERS*PIX_W-1:0]      layer_pix,
   input  logic                             cfg_we,
   input  logic [$clog2(2*NUM_LAYERS+1)-1:0] cfg_addr,
   input  logic [7:0]                       cfg_data,
   output logic                             cfg_busy,
   output logic [BANK_W+PIX_W-1:0]          pix_out,
   output logic [LSEL_W-1:0]                layer_sel,
   output logic                             shadow,
   output logic                             pix_valid
);

   localparam int               ADDR_W = $clog2(2 * NUM_LAYERS + 1);
   localparam logic [LSEL_W-1:0] BD_SEL = LSEL_W'(backdrop_index(NUM_LAYERS));

   logic [NUM_LAYERS-1:0][LSEL_W-1:0] w_rank;
   logic [NUM_LAYERS-1:0][BANK_W-1:0] w_bank;
   ctrl_t                             w_ctrl;
   logic [NUM_LAYERS-1:0][PIX_W-1:0]  w_code;
   logic [NUM_LAYERS-1:0]             w_opaque;
   logic                              w_demote;
   logic                              w_shadow_hit;
   logic                              w_found;
   logic [LSEL_W-1:0]                 w_win_sel;
   logic [PIX_W-1:0]                  w_win_code;
   logic [BANK_W-1:0]                 w_s2_bank;

   logic [LSEL_W-1:0]                 r_s1_sel;
   logic [PIX_W-1:0]                  r_s1_code;
   logic                              r_s1_shadow;
   logic                              r_s1_hblank;
   logic [BANK_W+PIX_W-1:0]           r_pix_out;
   logic [LSEL_W-1:0]                 r_layer_sel;
   logic                              r_shadow;
   logic                              r_pix_valid;

   prio_cfg_regs #(
      .NUM_LAYERS (NUM_LAYERS),
      .LSEL_W     (LSEL_W),
      .BANK_W     (BANK_W),
      .ADDR_W     (ADDR_W)
   ) u_cfg (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_hblank (hblank),
      .i_we     (cfg_we),
      .i_addr   (cfg_addr),
      .i_data   (cfg_data),
      .o_busy   (cfg_busy),
      .o_rank   (w_rank),
      .o_bank   (w_bank),
      .o_ctrl   (w_ctrl)
   );

   assign w_code = layer_pix;

   // Opacity per layer; a shadow pen on layer 0 hides the sprite and flags darkening instead
   always_comb begin
      w_shadow_hit = w_ctrl.shadow_en && (w_code[0] == SHADOW_PEN);
      w_demote     = w_ctrl.spr_pri_en && w_code[0][PIX_W-1];
      for (int i = 0; i < NUM_LAYERS; i++)
         w_opaque[i] = (w_code[i][TRANS_BITS-1:0] != {TRANS_BITS{1'b1}});
      if (w_shadow_hit)
         w_opaque[0] = 1'b0;
   end

   // Winner search in rank order; a demoted sprite is pulled out and re-inserted after rank slot 1
   always_comb begin
      w_found    = 1'b0;
      w_win_sel  = BD_SEL;
      w_win_code = '0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
         for (int j = 0; j < NUM_LAYERS; j++) begin
            if (!w_found && (w_rank[k] == LSEL_W'(j)) && w_opaque[j] &&
                !(w_demote && (j == 0))) begin
               w_found    = 1'b1;
               w_win_sel  = LSEL_W'(j);
               w_win_code = w_code[j];
            end
         end
         if ((k == 1) && w_demote && !w_found && w_opaque[0]) begin
            w_found    = 1'b1;
            w_win_sel  = '0;
            w_win_code = w_code[0];
         end
      end
   end

   // Stage 1 register: winner index, its code, shadow request and blanking state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_sel    <= '0;
         r_s1_code   <= '0;
         r_s1_shadow <= 1'b0;
         r_s1_hblank <= 1'b0;
      end else if (ce_pix) begin
         r_s1_sel    <= w_win_sel;
         r_s1_code   <= w_win_code;
         r_s1_shadow <= w_shadow_hit;
         r_s1_hblank <= hblank;
      end
   end

   // Colour bank of the stage-1 winner; the backdrop uses the ctrl bank field
   always_comb begin
      w_s2_bank = BANK_W'(w_ctrl.bd_bank);
      for (int j = 0; j < NUM_LAYERS; j++) begin
         if (r_s1_sel == LSEL_W'(j))
            w_s2_bank = w_bank[j];
      end
   end

   // Stage 2 register: palette address and companion outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pix_out   <= '0;
         r_layer_sel <= '0;
         r_shadow    <= 1'b0;
         r_pix_valid <= 1'b0;
      end else if (ce_pix) begin
         r_pix_out   <= {w_s2_bank, r_s1_code};
         r_layer_sel <= r_s1_sel;
         r_shadow    <= r_s1_shadow;
         r_pix_valid <= !r_s1_hblank;
      end
   end

   assign pix_out   = r_pix_out;
   assign layer_sel = r_layer_sel;
   assign shadow    = r_shadow;
   assign pix_valid = r_pix_valid;

endmodule

// File: tb/tb_layer_prio_mixer.sv
// Directed bench for layer_prio_mixer with N=4, PIX_W=8, BANK_W=3.
module tb_layer_prio_mixer;

   logic        clk;
   logic        rst_n;
   logic        ce_pix;
   logic        hblank;
   logic [31:0] layer_pix;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [7:0]  cfg_data;
   logic        cfg_busy;
   logic [10:0] pix_out;
   logic [2:0]  layer_sel;
   logic        shadow;
   logic        pix_valid;

   int checks;
   int failures;

   layer_prio_mixer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ce_pix    (ce_pix),
      .hblank    (hblank),
      .layer_pix (layer_pix),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_busy  (cfg_busy),
      .pix_out   (pix_out),
      .layer_sel (layer_sel),
      .shadow    (shadow),
      .pix_valid (pix_valid)
   );

   // 10 ns pixel clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] l0, input logic [7:0] l1,
                        input logic [7:0] l2, input logic [7:0] l3);
      layer_pix = {l3, l2, l1, l0};
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic hblank_pulse();
      hblank = 1'b1;
      tick();
      tick();
      hblank = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      checks++;
      if (pix_out !== 11'h000) begin
         failures++;
         $display("[TB] FAIL reset_pix_out got=%h exp=%h", pix_out, 11'h000);
      end
      checks++;
      if (layer_sel !== 3'd0 || shadow !== 1'b0 || pix_valid !== 1'b0 || cfg_busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags got sel=%0d sh=%b v=%b busy=%b exp 0/0/0/0",
                  layer_sel, shadow, pix_valid, cfg_busy);
      end
   endtask

   task automatic test_basic();
      drive(8'h07, 8'h23, 8'h07, 8'h07);
      tick();
      checks++;
      if (pix_out !== 11'h000) begin
         failures++;
         $display("[TB] FAIL latency_one_cycle got=%h exp=%h", pix_out, 11'h000);
      end
      tick();
      checks++;
      if (pix_out !== 11'h123 || layer_sel !== 3'd1 || shadow !== 1'b0 || pix_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL basic got pix=%h sel=%0d sh=%b v=%b exp pix=123 sel=1 sh=0 v=1",
                  pix_out, layer_sel, shadow, pix_valid);
      end
   endtask

   task automatic test_backdrop();
      drive(8'h07, 8'h17, 8'hA7, 8'hF7);
      tick(); tick();
      checks++;
      if (layer_sel !== 3'd4 || pix_out !== 11'h000) begin
         failures++;
         $display("[TB] FAIL backdrop got pix=%h sel=%0d exp pix=000 sel=4", pix_out, layer_sel);
      end
      cfg_write(4'd8, 8'h14);
      checks++;
      if (cfg_busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ctrl_busy got=%b exp=1", cfg_busy);
      end
      tick(); tick();
      checks++;
      if (pix_out !== 11'h000) begin
         failures++;
         $display("[TB] FAIL ctrl_deferred got=%h exp=%h", pix_out, 11'h000);
      end
      hblank = 1'b1;
      tick(); tick();
      checks++;
      if (cfg_busy !== 1'b0 || pix_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL hblank_commit got busy=%b v=%b exp busy=0 v=0", cfg_busy, pix_valid);
      end
      checks++;
      if (pix_out !== 11'h500) begin
         failures++;
         $display("[TB] FAIL backdrop_bank got=%h exp=%h", pix_out, 11'h500);
      end
      hblank = 1'b0;
      tick(); tick();
      checks++;
      if (pix_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL valid_after_blank got=%b exp=1", pix_valid);
      end
      cfg_write(4'd8, 8'h00);
      hblank_pulse();
   endtask

   task automatic test_rank();
      cfg_write(4'd0, 8'h02);
      cfg_write(4'd2, 8'h00);
      drive(8'h11, 8'h07, 8'h42, 8'h07);
      tick(); tick();
      checks++;
      if (cfg_busy !== 1'b1 || layer_sel !== 3'd0 || pix_out !== 11'h011) begin
         failures++;
         $display("[TB] FAIL rank_old_order got busy=%b sel=%0d pix=%h exp busy=1 sel=0 pix=011",
                  cfg_busy, layer_sel, pix_out);
      end
      hblank_pulse();
      tick(); tick();
      checks++;
      if (layer_sel !== 3'd2 || pix_out !== 11'h242) begin
         failures++;
         $display("[TB] FAIL rank_new_order got sel=%0d pix=%h exp sel=2 pix=242", layer_sel, pix_out);
      end
      cfg_write(4'd0, 8'h00);
      cfg_write(4'd2, 8'h02);
      hblank_pulse();
   endtask

   task automatic test_same_cycle_write();
      drive(8'h07, 8'h07, 8'h07, 8'h07);
      hblank   = 1'b1;
      cfg_we   = 1'b1;
      cfg_addr = 4'd8;
      cfg_data = 8'h14;
      tick();
      cfg_we   = 1'b0;
      tick(); tick();
      checks++;
      if (cfg_busy !== 1'b1 || pix_out !== 11'h000) begin
         failures++;
         $display("[TB] FAIL edge_write got busy=%b pix=%h exp busy=1 pix=000", cfg_busy, pix_out);
      end
      hblank = 1'b0;
      tick();
      hblank_pulse();
      tick(); tick();
      checks++;
      if (cfg_busy !== 1'b0 || pix_out !== 11'h500) begin
         failures++;
         $display("[TB] FAIL edge_write_next got busy=%b pix=%h exp busy=0 pix=500", cfg_busy, pix_out);
      end
      cfg_write(4'd8, 8'h00);
      hblank_pulse();
   endtask

   task automatic test_last_write_wins();
      cfg_write(4'd5, 8'h03);
      cfg_write(4'd5, 8'h06);
      hblank_pulse();
      drive(8'h07, 8'h23, 8'h07, 8'h07);
      tick(); tick();
      checks++;
      if (pix_out !== 11'h623) begin
         failures++;
         $display("[TB] FAIL last_write_wins got=%h exp=%h", pix_out, 11'h623);
      end
      cfg_write(4'd5, 8'h01);
      hblank_pulse();
   endtask

   task automatic test_demote();
      cfg_write(4'd8, 8'h01);
      hblank_pulse();
      drive(8'h81, 8'h10, 8'h07, 8'h07);
      tick(); tick();
      checks++;
      if (layer_sel !== 3'd1 || pix_out !== 11'h110) begin
         failures++;
         $display("[TB] FAIL demote_behind got sel=%0d pix=%h exp sel=1 pix=110", layer_sel, pix_out);
      end
      drive(8'h81, 8'h17, 8'h35, 8'h07);
      tick(); tick();
      checks++;
      if (layer_sel !== 3'd0 || pix_out !== 11'h081) begin
         failures++;
         $display("[TB] FAIL demote_wins got sel=%0d pix=%h exp sel=0 pix=081", layer_sel, pix_out);
      end
      drive(8'h01, 8'h10, 8'h07, 8'h07);
      tick(); tick();
      checks++;
      if (layer_sel !== 3'd0 || pix_out !== 11'h001) begin
         failures++;
         $display("[TB] FAIL no_demote got sel=%0d pix=%h exp sel=0 pix=001", layer_sel, pix_out);
      end
      cfg_write(4'd8, 8'h00);
      hblank_pulse();
   endtask

   task automatic test_shadow();
      drive(8'hFE, 8'h05, 8'h07, 8'h07);
      tick(); tick();
      checks++;
      if (shadow !== 1'b0 || layer_sel !== 3'd0 || pix_out !== 11'h0FE) begin
         failures++;
         $display("[TB] FAIL shadow_off got sh=%b sel=%0d pix=%h exp sh=0 sel=0 pix=0fe",
                  shadow, layer_sel, pix_out);
      end
      cfg_write(4'd8, 8'h02);
      hblank_pulse();
      tick(); tick();
      checks++;
      if (shadow !== 1'b1 || layer_sel !== 3'd1 || pix_out !== 11'h105) begin
         failures++;
         $display("[TB] FAIL shadow_on got sh=%b sel=%0d pix=%h exp sh=1 sel=1 pix=105",
                  shadow, layer_sel, pix_out);
      end
      cfg_write(4'd8, 8'h00);
      hblank_pulse();
   endtask

   task automatic test_ce_pix();
      drive(8'h07, 8'h23, 8'h07, 8'h07);
      tick(); tick();
      drive(8'h07, 8'h07, 8'h42, 8'h07);
      ce_pix = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (pix_out !== 11'h123) begin
         failures++;
         $display("[TB] FAIL ce_hold got=%h exp=%h", pix_out, 11'h123);
      end
      ce_pix = 1'b1;
      tick();
      checks++;
      if (pix_out !== 11'h123) begin
         failures++;
         $display("[TB] FAIL ce_first_enable got=%h exp=%h", pix_out, 11'h123);
      end
      ce_pix = 1'b0;
      tick();
      ce_pix = 1'b1;
      tick();
      checks++;
      if (pix_out !== 11'h242 || layer_sel !== 3'd2) begin
         failures++;
         $display("[TB] FAIL ce_second_enable got pix=%h sel=%0d exp pix=242 sel=2", pix_out, layer_sel);
      end
   endtask

   task automatic test_reset_pending();
      cfg_write(4'd8, 8'h14);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (pix_out !== 11'h000 || layer_sel !== 3'd0 || pix_valid !== 1'b0 || cfg_busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL async_reset got pix=%h sel=%0d v=%b busy=%b exp all 0",
                  pix_out, layer_sel, pix_valid, cfg_busy);
      end
      tick();
      rst_n = 1'b1;
      drive(8'h07, 8'h07, 8'h07, 8'h07);
      hblank_pulse();
      tick(); tick();
      checks++;
      if (pix_out !== 11'h000 || layer_sel !== 3'd4) begin
         failures++;
         $display("[TB] FAIL pending_discarded got pix=%h sel=%0d exp pix=000 sel=4", pix_out, layer_sel);
      end
   endtask

   // Sequence all scenarios and report the result
   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      ce_pix    = 1'b1;
      hblank    = 1'b0;
      layer_pix = '0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_data  = '0;
      tick(); tick();
      test_reset();
      rst_n = 1'b1;
      test_basic();
      test_backdrop();
      test_rank();
      test_same_cycle_write();
      test_last_write_wins();
      test_demote();
      test_shadow();
      test_ce_pix();
      test_reset_pending();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
